// File: rtl/can_destuff_ctrl.sv
// ---------------------------------------------------------------------------
// can_destuff_ctrl
// Receive-side CAN bit destuffing controller. It integrates onto the bus
// (IDLE_LEN recessive samples), detects SOF, strips stuff bits inside the
// stuffed region and flags stuff-rule violations. All outputs are registered
// and respond one cycle after the qualifying sample.
//
// Ports
//   CLK          in   clock, rising edge
//   RST          in   synchronous active-high reset
//   sample_valid in   one-cycle strobe qualifying rx_bit
//   rx_bit       in   sampled bus level (1 = recessive, 0 = dominant)
//   stuff_en     in   high while the bit-stuffed region is active
//   frame_done   in   one-cycle end-of-frame pulse from the frame decoder
//   data_valid   out  one-cycle pulse, destuffed bit on data_bit
//   data_bit     out  destuffed bit
//   stuff_drop   out  one-cycle pulse, a stuff bit was removed
//   stuff_err    out  one-cycle pulse, stuff-rule violation
//   bus_idle     out  high while state is IDLE
//   state        out  INTEG=0, IDLE=1, FRAME=2, ERR=3
// ---------------------------------------------------------------------------
module can_destuff_ctrl #(
   parameter int STUFF_LEN = 5,
   parameter int IDLE_LEN  = 11
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       sample_valid,
   input  logic       rx_bit,
   input  logic       stuff_en,
   input  logic       frame_done,
   output logic       data_valid,
   output logic       data_bit,
   output logic       stuff_drop,
   output logic       stuff_err,
   output logic       bus_idle,
   output logic [1:0] state
);

   localparam int CW = $clog2(STUFF_LEN + 1);
   localparam int IW = $clog2(IDLE_LEN + 1);

   localparam logic [1:0] INTEG = 2'd0;
   localparam logic [1:0] IDLE  = 2'd1;
   localparam logic [1:0] FRAME = 2'd2;
   localparam logic [1:0] ERR   = 2'd3;

   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_MAX   = CW'(STUFF_LEN);
   localparam logic [IW-1:0] ICNT_LAST = IW'(IDLE_LEN - 1);

   logic [CW-1:0] cnt, cnt_n;
   logic          last, last_n;
   logic [IW-1:0] icnt, icnt_n;
   logic [1:0]    state_n;
   logic          dv_n, db_n, drop_n, err_n;

   // Next-state and output decode. Pulses default low so they only rise in
   // the cycle after a qualifying sample; data_bit holds its last value.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      last_n  = last;
      icnt_n  = icnt;
      dv_n    = 1'b0;
      db_n    = data_bit;
      drop_n  = 1'b0;
      err_n   = 1'b0;
      case (state)
         INTEG: begin
            if (sample_valid) begin
               if (rx_bit) begin
                  // The sample that would make icnt reach IDLE_LEN completes integration
                  if (icnt == ICNT_LAST) begin
                     state_n = IDLE;
                     icnt_n  = '0;
                  end else begin
                     icnt_n = icnt + 1'b1;
                  end
               end else begin
                  icnt_n = '0;
               end
            end
         end
         IDLE: begin
            if (sample_valid && !rx_bit) begin
               dv_n    = 1'b1;
               db_n    = 1'b0;
               last_n  = 1'b0;
               cnt_n   = CNT_ONE;
               state_n = FRAME;
            end
         end
         FRAME: begin
            // End of frame returns to IDLE, but a coincident stuff error
            // below overrides this and goes to ERR instead
            if (frame_done) begin
               state_n = IDLE;
            end
            if (sample_valid) begin
               if (!stuff_en) begin
                  dv_n   = 1'b1;
                  db_n   = rx_bit;
                  cnt_n  = CNT_ONE;
                  last_n = rx_bit;
               end else if (cnt < CNT_MAX) begin
                  dv_n = 1'b1;
                  db_n = rx_bit;
                  if (rx_bit == last) begin
                     cnt_n = cnt + 1'b1;
                  end else begin
                     cnt_n  = CNT_ONE;
                     last_n = rx_bit;
                  end
               end else if (rx_bit != last) begin
                  // Stuff bit: dropped, but it opens a new run of its own polarity
                  drop_n = 1'b1;
                  last_n = rx_bit;
                  cnt_n  = CNT_ONE;
               end else begin
                  err_n   = 1'b1;
                  state_n = ERR;
               end
            end
         end
         default: begin
            // ERR lasts one cycle; any sample seen here is thrown away
            state_n = INTEG;
            icnt_n  = '0;
         end
      endcase
   end

   // State and registered outputs; reset overrides every other input
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= INTEG;
         icnt       <= '0;
         cnt        <= '0;
         last       <= 1'b1;
         data_bit   <= 1'b1;
         data_valid <= 1'b0;
         stuff_drop <= 1'b0;
         stuff_err  <= 1'b0;
         bus_idle   <= 1'b0;
      end else begin
         state      <= state_n;
         icnt       <= icnt_n;
         cnt        <= cnt_n;
         last       <= last_n;
         data_bit   <= db_n;
         data_valid <= dv_n;
         stuff_drop <= drop_n;
         stuff_err  <= err_n;
         bus_idle   <= (state_n == IDLE);
      end
   end

endmodule
